// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, held in pending registers, and committed when the busy count expires.
module mul_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed, a_neg, b_neg, div_by_zero;
    logic [31:0] a_mag, b_mag, quot_mag, rem_mag, quot, rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One magnitude divider serves both DIV and DIVU; signs are reapplied afterwards.
    // Negating 0x80000000 yields itself, so the -2^31 / -1 case wraps without special handling.
    assign div_signed  = (op == OpDiv);
    assign a_neg       = div_signed & a[31];
    assign b_neg       = div_signed & b[31];
    assign div_by_zero = (b == 32'd0);
    assign a_mag       = a_neg ? (32'd0 - a) : a;
    assign b_mag       = div_by_zero ? 32'd1 : (b_neg ? (32'd0 - b) : b);
    assign quot_mag    = a_mag / b_mag;
    assign rem_mag     = a_mag % b_mag;
    assign quot        = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
    assign rem         = a_neg ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMult, OpMultu: begin
                            {pend_hi_d, pend_lo_d} = (op == OpMult) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CntW'(MUL_CYCLES);
                            state_d   = StBusy;
                        end
                        OpDiv, OpDivu: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            pend_wr_d = !div_by_zero;
                            cnt_d     = CntW'(DIV_CYCLES);
                            state_d   = StBusy;
                        end
                        OpMthi:  hi_d = a;
                        OpMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
